// File: rtl/rubik_pkg.sv
// rubik_pkg -- shared cube-move definitions.
//   Face and turn encodings, scrambler FSM states and the axis helper.
//   Shared by the scramble generator and the cube-state updater.
//   No ports (package).
package rubik_pkg;

    localparam int NUM_FACES = 6;

    // Marks "no previous face" in the scrambler's history register.
    localparam logic [2:0] FACE_NONE = 3'd7;

    typedef enum logic [2:0] {
        FACE_U = 3'd0,
        FACE_D = 3'd1,
        FACE_L = 3'd2,
        FACE_R = 3'd3,
        FACE_F = 3'd4,
        FACE_B = 3'd5
    } face_t;

    typedef enum logic [1:0] {
        TURN_CW   = 2'd0,
        TURN_CCW  = 2'd1,
        TURN_HALF = 2'd2
    } turn_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_HOLD,
        ST_DONE
    } scr_state_t;

    // Opposite faces share an axis: U/D=0, L/R=1, F/B=2.
    function automatic logic [1:0] axis_of(input logic [2:0] face);
        return face[2:1];
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois -- seedable right-shifting Galois LFSR.
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset, loads SEED
//   en       in   advance one step
//   load     in   load load_val (takes priority over en); zero maps to SEED
//   load_val in   W-bit seed
//   q        out  W-bit state, never zero
module lfsr_galois #(
    parameter int           W    = 32,
    parameter logic [W-1:0] TAPS = W'(32'h8020_0003),
    parameter logic [W-1:0] SEED = W'(32'hACE1_2468)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else if (load) begin
            // A zero seed would lock the register, so fall back to SEED.
            q <= (load_val == '0) ? SEED : load_val;
        end else if (en) begin
            q <= {1'b0, q[W-1:1]} ^ (q[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/scramble_gen.sv
// scramble_gen -- emits a SEQ_LEN-move Rubik's-cube scramble on a valid/ready stream.
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   start       in   pulse: begin a scramble (ignored while busy)
//   seed_load   in   load seed_in into the LFSR (IDLE only)
//   seed_in     in   LFSR_W-bit seed, 0 selects SEED
//   move_valid  out  move_face/move_turn hold a move
//   move_ready  in   consumer accepts on move_valid & move_ready
//   move_face   out  0=U 1=D 2=L 3=R 4=F 5=B
//   move_turn   out  0=CW 1=CCW 2=180
//   busy        out  scramble in progress
//   done        out  one-cycle pulse after the last move is accepted
// Build option: SCRAMBLE_AXIS_FILTER_EN also rejects a face that follows its
//   opposite face in descending order (D after U allowed, U after D rejected).
module scramble_gen
    import rubik_pkg::*;
#(
    parameter int                LFSR_W  = 32,
    parameter logic [LFSR_W-1:0] TAPS    = LFSR_W'(32'h8020_0003),
    parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(32'hACE1_2468),
    parameter int                SEQ_LEN = 20,
    parameter int                CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              move_valid,
    input  logic              move_ready,
    output logic [2:0]        move_face,
    output logic [1:0]        move_turn,
    output logic              busy,
    output logic              done
);

    scr_state_t        state, state_nx;
    logic [CNT_W-1:0]  count;
    logic [2:0]        prev_face;
    logic              prev_vld;
    logic [LFSR_W-1:0] lfsr_q;
    logic [2:0]        cand_face;
    logic [1:0]        cand_turn;
    logic              cand_ok;
    logic              lfsr_nz;

    lfsr_galois #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .en       (state == ST_GEN),
        .load     ((state == ST_IDLE) && seed_load),
        .load_val (seed_in),
        .q        (lfsr_q)
    );

    assign cand_face = lfsr_q[2:0];
    assign cand_turn = lfsr_q[4:3];
    // Always true for a healthy LFSR; refuses candidates from a stuck register.
    assign lfsr_nz   = |lfsr_q;

    // Rejection sampling: out-of-range codes and same-face repeats are
    // discarded so accepted moves stay uniform over the legal set.
    always_comb begin
        cand_ok = lfsr_nz
                && (cand_face < 3'(NUM_FACES))
                && (cand_turn <= 2'(TURN_HALF))
                && !(prev_vld && (cand_face == prev_face));
`ifdef SCRAMBLE_AXIS_FILTER_EN
        if (prev_vld && (axis_of(cand_face) == axis_of(prev_face))
                     && (cand_face < prev_face))
            cand_ok = 1'b0;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_GEN;
            ST_GEN:  if (cand_ok) state_nx = ST_HOLD;
            ST_HOLD: if (move_ready) state_nx = (count == CNT_W'(1)) ? ST_DONE : ST_GEN;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            prev_face <= FACE_NONE;
            prev_vld  <= 1'b0;
            move_face <= '0;
            move_turn <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (start) begin
                    count    <= CNT_W'(SEQ_LEN);
                    prev_vld <= 1'b0;
                end
                ST_GEN: if (cand_ok) begin
                    move_face <= cand_face;
                    move_turn <= cand_turn;
                end
                ST_HOLD: if (move_ready) begin
                    prev_face <= move_face;
                    prev_vld  <= 1'b1;
                    count     <= count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Decoded straight from the state register so an async reset clears
    // them immediately.
    assign move_valid = (state == ST_HOLD);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

endmodule
